// File: rtl/aes_pkg.sv
// Shared AES definitions: round/word types, Rcon table and the S-box lookup.
// Pure constants and functions; no state, no flow control.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] round_key_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        KX_IDLE,
        KX_EXPAND,
        KX_DONE
    } kx_state_t;

    // Entry i sits at bits [8*(10-i) +: 8]; entry 0 is unused padding.
    localparam logic [87:0] RCON_TABLE = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Byte b sits at bits [8*(255-b) +: 8], so row 0 of the FIPS-197 table is the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] val;
        val = 8'h00;
        if (idx <= 4'd10)
            val = RCON_TABLE[8*(10-int'(idx)) +: 8];
        return val;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[8*(255-int'(b)) +: 8];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational, zero latency, no flow control.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t word,
    output word_t sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]),
                  sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: one round key per clock into an 11-entry bank, done 11 edges after start.
// Combinational zero-latency read port; start is ignored while expanding (no backpressure).
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [127:0]       key_in,
    input  logic [ROUND_W-1:0] desired_round,
    output logic [127:0]       round_key,
    output logic               key_expansion_done,
    output logic               busy
);

    kx_state_t          state;
    logic [ROUND_W-1:0] cnt;
    round_key_t         bank [0:NR];

    round_key_t prev_key;
    round_key_t next_key;
    word_t      rot_w3;
    word_t      sub_w3;
    word_t      t_word;
    word_t      n0, n1, n2, n3;

    // cnt names the entry being written, so the source entry is cnt-1.
    always_comb begin
        prev_key = '0;
        for (int k = 0; k < NR; k++) begin
            if (ROUND_W'(k + 1) == cnt)
                prev_key = bank[k];
        end
    end

    assign rot_w3 = {prev_key[23:0], prev_key[31:24]};

    aes_sub_word u_sub_word (
        .word (rot_w3),
        .sub  (sub_w3)
    );

    assign t_word   = sub_w3 ^ {rcon(4'(cnt)), 24'h000000};
    assign n0       = prev_key[127:96] ^ t_word;
    assign n1       = prev_key[95:64]  ^ n0;
    assign n2       = prev_key[63:32]  ^ n1;
    assign n3       = prev_key[31:0]   ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // Out-of-range indices fall through to zero.
    always_comb begin
        round_key = '0;
        for (int k = 0; k <= NR; k++) begin
            if (ROUND_W'(k) == desired_round)
                round_key = bank[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= KX_IDLE;
            cnt                <= '0;
            key_expansion_done <= 1'b0;
            busy               <= 1'b0;
            for (int k = 0; k <= NR; k++)
                bank[k] <= '0;
        end else begin
            case (state)
                KX_IDLE, KX_DONE: begin
                    if (start) begin
                        bank[0]            <= key_in;
                        cnt                <= ROUND_W'(1);
                        key_expansion_done <= 1'b0;
                        busy               <= 1'b1;
                        state              <= KX_EXPAND;
                    end
                end
                KX_EXPAND: begin
                    for (int k = 1; k <= NR; k++) begin
                        if (ROUND_W'(k) == cnt)
                            bank[k] <= next_key;
                    end
                    cnt <= cnt + ROUND_W'(1);
                    if (cnt == ROUND_W'(NR)) begin
                        key_expansion_done <= 1'b1;
                        busy               <= 1'b0;
                        state              <= KX_DONE;
                    end
                end
                default: state <= KX_IDLE;
            endcase
        end
    end

endmodule
